// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared FSM encoding, register-zero constant and load-latency check
package hazard_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERROR    = 2'd2;

    localparam int REG_ZERO     = 0;
    localparam int LOAD_LAT_MIN = 1;
    localparam int LOAD_LAT_MAX = 2;

    function automatic bit load_lat_ok(input int lat);
        return (lat >= LOAD_LAT_MIN) && (lat <= LOAD_LAT_MAX);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - pipeline-side signal bundle of the hazard/stall controller
interface hazard_stall_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic [REG_W-1:0] ifIdRs;
    logic [REG_W-1:0] ifIdRt;
    logic             ifIdUsesRs;
    logic             ifIdUsesRt;
    logic             ifIdBranch;
    logic             idExMemRead;
    logic             idExRegWrite;
    logic [REG_W-1:0] idExDst;
    logic             exMemMemRead;
    logic [REG_W-1:0] exMemDst;
    logic             memReq;
    logic             memReady;
    logic             pcWrite;
    logic             ifWrite;
    logic             resetIdControl;
    logic             pipeFreeze;
    logic             memTimeout;
    logic [CNT_W-1:0] loadStallCnt;
    logic [CNT_W-1:0] freezeCnt;

    modport master (
        output ifIdRs, ifIdRt, ifIdUsesRs, ifIdUsesRt, ifIdBranch,
               idExMemRead, idExRegWrite, idExDst, exMemMemRead, exMemDst,
               memReq, memReady,
        input  pcWrite, ifWrite, resetIdControl, pipeFreeze, memTimeout,
               loadStallCnt, freezeCnt
    );

    modport slave (
        input  ifIdRs, ifIdRt, ifIdUsesRs, ifIdUsesRt, ifIdBranch,
               idExMemRead, idExRegWrite, idExDst, exMemMemRead, exMemDst,
               memReq, memReady,
        output pcWrite, ifWrite, resetIdControl, pipeFreeze, memTimeout,
               loadStallCnt, freezeCnt
    );
endinterface

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - compares both ID sources against one destination; $zero never matches
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    input  logic             uses_rs_i,
    input  logic             uses_rt_i,
    input  logic [REG_W-1:0] dst_i,
    output logic             match_o
);
    logic dst_live;

    assign dst_live = (dst_i != REG_W'(REG_ZERO));
    assign match_o  = dst_live && ((uses_rs_i && (rs_i == dst_i)) ||
                                   (uses_rt_i && (rt_i == dst_i)));
endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use/branch hazard stall, memory freeze FSM and watchdog
// Optional performance counters built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int LOAD_LAT    = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    hazard_stall_unit_if.slave  bus
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    generate
        if (!load_lat_ok(LOAD_LAT) || (MEM_TIMEOUT < 1)) begin : g_bad_cfg
            $error("hazard_stall_unit: LOAD_LAT must be 1 or 2 and MEM_TIMEOUT at least 1");
        end
    endgenerate

    logic ex_match;
    logic mem_match;
    logic load_use_hz;
    logic branch_hz;
    logic stall;
    logic freeze_req;

    hazard_src_match #(.REG_W(REG_W)) u_match_ex (
        .rs_i      (bus.ifIdRs),
        .rt_i      (bus.ifIdRt),
        .uses_rs_i (bus.ifIdUsesRs),
        .uses_rt_i (bus.ifIdUsesRt),
        .dst_i     (bus.idExDst),
        .match_o   (ex_match)
    );

    hazard_src_match #(.REG_W(REG_W)) u_match_mem (
        .rs_i      (bus.ifIdRs),
        .rt_i      (bus.ifIdRt),
        .uses_rs_i (bus.ifIdUsesRs),
        .uses_rt_i (bus.ifIdUsesRt),
        .dst_i     (bus.exMemDst),
        .match_o   (mem_match)
    );

    // A two-stage load keeps blocking consumers while it sits in MEM.
    assign load_use_hz = (bus.idExMemRead && ex_match) ||
                         ((LOAD_LAT == 2) && bus.exMemMemRead && mem_match);
    assign branch_hz   = bus.ifIdBranch &&
                         ((bus.idExRegWrite && ex_match) || (bus.exMemMemRead && mem_match));
    assign stall       = load_use_hz || branch_hz;
    assign freeze_req  = bus.memReq && !bus.memReady;

    logic [1:0]      state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [WC_W:0]   wait_next;

    // wait_cnt_q is zero in RUN, so the same increment serves the RUN->MEM_WAIT entry.
    assign wait_next = {1'b0, wait_cnt_q} + (WC_W+1)'(1);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if (freeze_req) begin
                    wait_cnt_d = wait_next[WC_W-1:0];
                    state_d    = (wait_next >= (WC_W+1)'(MEM_TIMEOUT)) ? ST_ERROR : ST_MEM_WAIT;
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    logic pc_write, if_write, reset_id_ctrl, pipe_freeze, mem_timeout;

    always_comb begin
        pc_write      = 1'b1;
        if_write      = 1'b1;
        reset_id_ctrl = 1'b0;
        pipe_freeze   = 1'b0;
        mem_timeout   = 1'b0;
        if (reset) begin
            pc_write      = 1'b0;
            if_write      = 1'b0;
            reset_id_ctrl = 1'b1;
        end else if (state_q == ST_ERROR) begin
            pc_write    = 1'b0;
            if_write    = 1'b0;
            pipe_freeze = 1'b1;
            mem_timeout = 1'b1;
        end else if (freeze_req) begin
            pc_write    = 1'b0;
            if_write    = 1'b0;
            pipe_freeze = 1'b1;
        end else if (stall) begin
            pc_write      = 1'b0;
            if_write      = 1'b0;
            reset_id_ctrl = 1'b1;
        end
    end

    assign bus.pcWrite        = pc_write;
    assign bus.ifWrite        = if_write;
    assign bus.resetIdControl = reset_id_ctrl;
    assign bus.pipeFreeze     = pipe_freeze;
    assign bus.memTimeout     = mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] load_stall_cnt_q;
    logic [CNT_W-1:0] freeze_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_stall_cnt_q <= '0;
            freeze_cnt_q     <= '0;
        end else begin
            if (stall && !pipe_freeze && !(&load_stall_cnt_q))
                load_stall_cnt_q <= load_stall_cnt_q + CNT_W'(1);
            if (pipe_freeze && !(&freeze_cnt_q))
                freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
        end
    end

    assign bus.loadStallCnt = load_stall_cnt_q;
    assign bus.freezeCnt    = freeze_cnt_q;
`else
    assign bus.loadStallCnt = '0;
    assign bus.freezeCnt    = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed-vector scoreboard bench for LOAD_LAT=1 and LOAD_LAT=2 builds
module tb_hazard_stall_unit;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [4:0] NRM = 5'b11000;
    localparam logic [4:0] STL = 5'b00100;
    localparam logic [4:0] FRZ = 5'b00010;
    localparam logic [4:0] ERR = 5'b00011;
    localparam logic [4:0] RST = 5'b00100;

    typedef struct {
        logic        rst, pulse;
        logic [4:0]  rs;  logic urs;
        logic [4:0]  rt;  logic urt;
        logic        br, exmr, exrw;
        logic [4:0]  exd;
        logic        mmr;
        logic [4:0]  mmd;
        logic        mreq, mrdy;
        logic [4:0]  e1, e2;
        logic        chk;
        logic [31:0] l1, l2, f;
        int          idx;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_stall_unit_if #(.REG_W(5), .CNT_W(32)) bus1 ();
    hazard_stall_unit_if #(.REG_W(5), .CNT_W(32)) bus2 ();

    hazard_stall_unit #(.REG_W(5), .LOAD_LAT(1), .MEM_TIMEOUT(4), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));
    hazard_stall_unit #(.REG_W(5), .LOAD_LAT(2), .MEM_TIMEOUT(4), .CNT_W(32)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave));

    vec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   nvec  = 0;

    function automatic vec_t V(input logic rst, pulse, input logic [4:0] rs, input logic urs,
                               input logic [4:0] rt, input logic urt, input logic br, exmr, exrw,
                               input logic [4:0] exd, input logic mmr, input logic [4:0] mmd,
                               input logic mreq, mrdy, input logic [4:0] e1, e2);
        vec_t v;
        v.rst = rst; v.pulse = pulse; v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt;
        v.br = br; v.exmr = exmr; v.exrw = exrw; v.exd = exd; v.mmr = mmr; v.mmd = mmd;
        v.mreq = mreq; v.mrdy = mrdy; v.e1 = e1; v.e2 = e2;
        v.chk = 1'b0; v.l1 = '0; v.l2 = '0; v.f = '0; v.idx = 0;
        return v;
    endfunction

    function automatic vec_t C(input vec_t vin, input int l1, l2, f);
        vec_t v = vin;
        v.chk = 1'b1;
        v.l1  = PERF ? 32'(l1) : 32'd0;
        v.l2  = PERF ? 32'(l2) : 32'd0;
        v.f   = PERF ? 32'(f)  : 32'd0;
        return v;
    endfunction

    task automatic step(input vec_t vin);
        vec_t v = vin;
        @(posedge clk);
        #1;
        reset = v.rst;
        bus1.ifIdRs = v.rs;       bus2.ifIdRs = v.rs;
        bus1.ifIdRt = v.rt;       bus2.ifIdRt = v.rt;
        bus1.ifIdUsesRs = v.urs;  bus2.ifIdUsesRs = v.urs;
        bus1.ifIdUsesRt = v.urt;  bus2.ifIdUsesRt = v.urt;
        bus1.ifIdBranch = v.br;   bus2.ifIdBranch = v.br;
        bus1.idExMemRead = v.exmr;  bus2.idExMemRead = v.exmr;
        bus1.idExRegWrite = v.exrw; bus2.idExRegWrite = v.exrw;
        bus1.idExDst = v.exd;     bus2.idExDst = v.exd;
        bus1.exMemMemRead = v.mmr; bus2.exMemMemRead = v.mmr;
        bus1.exMemDst = v.mmd;    bus2.exMemDst = v.mmd;
        bus1.memReq = v.mreq;     bus2.memReq = v.mreq;
        bus1.memReady = v.mrdy;   bus2.memReady = v.mrdy;
        v.idx = nvec;
        nvec++;
        exp_q.push_back(v);
        if (v.pulse) begin
            reset = 1'b1;
            #2;
            reset = 1'b0;
        end
    endtask

    task automatic cmp(input string name, input int idx, input int d,
                       input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s vec=%0d dut%0d actual=%0h required=%0h", name, idx, d, act, req);
        end
    endtask

    initial begin : monitor
        vec_t v;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                v = exp_q.pop_front();
                cmp("outs", v.idx, 1, 32'({bus1.pcWrite, bus1.ifWrite, bus1.resetIdControl,
                                           bus1.pipeFreeze, bus1.memTimeout}), 32'(v.e1));
                cmp("outs", v.idx, 2, 32'({bus2.pcWrite, bus2.ifWrite, bus2.resetIdControl,
                                           bus2.pipeFreeze, bus2.memTimeout}), 32'(v.e2));
                if (v.chk) begin
                    cmp("loadStallCnt", v.idx, 1, bus1.loadStallCnt, v.l1);
                    cmp("loadStallCnt", v.idx, 2, bus2.loadStallCnt, v.l2);
                    cmp("freezeCnt",    v.idx, 1, bus1.freezeCnt, v.f);
                    cmp("freezeCnt",    v.idx, 2, bus2.freezeCnt, v.f);
                end
            end
        end
    end

    initial begin : stimulus
        //         rst pl rs urs rt urt br exmr exrw exd mmr mmd mreq mrdy  e1   e2
        step(C(V(1, 0,  0, 0,  0, 0,  0, 0,   0,   0,  0,  0,  0,   0,   RST, RST), 0, 0, 0));
        step(  V(0, 0,  0, 0,  0, 0,  0, 0,   0,   0,  0,  0,  0,   0,   NRM, NRM));
        step(  V(0, 0,  9, 1,  3, 1,  0, 1,   1,   9,  0,  0,  0,   0,   STL, STL));
        step(  V(0, 0,  9, 1,  3, 1,  0, 0,   0,   0,  1,  9,  0,   0,   NRM, STL));
        step(  V(0, 0,  9, 1,  3, 1,  0, 0,   0,   0,  0,  0,  0,   0,   NRM, NRM));
        step(  V(0, 0,  0, 1,  4, 1,  0, 1,   1,   0,  0,  0,  0,   0,   NRM, NRM));
        step(  V(0, 0,  0, 1,  4, 1,  0, 0,   0,   0,  1,  0,  0,   0,   NRM, NRM));
        step(  V(0, 0,  3, 1, 10, 0,  0, 1,   1,  10,  0,  0,  0,   0,   NRM, NRM));
        step(  V(0, 0,  3, 1, 10, 1,  0, 1,   1,  10,  0,  0,  0,   0,   STL, STL));
        step(  V(0, 0, 10, 1, 11, 1,  1, 0,   1,  10,  0,  0,  0,   0,   STL, STL));
        step(  V(0, 0, 10, 1, 11, 1,  1, 0,   0,   0,  0, 10,  0,   0,   NRM, NRM));
        step(  V(0, 0, 10, 1, 11, 1,  1, 1,   1,  10,  0,  0,  0,   0,   STL, STL));
        step(  V(0, 0, 10, 1, 11, 1,  1, 0,   0,   0,  1, 10,  0,   0,   STL, STL));
        step(  V(0, 0, 10, 1, 11, 1,  1, 0,   0,   0,  0,  0,  0,   0,   NRM, NRM));
        step(C(V(0, 0,  9, 1,  3, 1,  0, 1,   1,   9,  0,  0,  1,   0,   FRZ, FRZ), 5, 6, 0));
        step(  V(0, 0,  9, 1,  3, 1,  0, 1,   1,   9,  0,  0,  1,   0,   FRZ, FRZ));
        step(  V(0, 0,  9, 1,  3, 1,  0, 1,   1,   9,  0,  0,  1,   0,   FRZ, FRZ));
        step(  V(0, 0,  9, 1,  3, 1,  0, 1,   1,   9,  0,  0,  1,   1,   STL, STL));
        step(C(V(0, 0,  0, 0,  0, 0,  0, 0,   0,   0,  0,  0,  0,   0,   NRM, NRM), 6, 7, 3));
        step(  V(0, 0,  0, 0,  0, 0,  0, 0,   0,   0,  0,  0,  1,   1,   NRM, NRM));
        for (int i = 0; i < 4; i++)
            step(V(0, 0, 0, 0,  0, 0,  0, 0,   0,   0,  0,  0,  1,   0,   FRZ, FRZ));
        step(  V(0, 0,  0, 0,  0, 0,  0, 0,   0,   0,  0,  0,  1,   1,   ERR, ERR));
        step(  V(0, 0,  9, 1,  3, 1,  0, 1,   1,   9,  0,  0,  0,   0,   ERR, ERR));
        step(C(V(0, 1,  0, 0,  0, 0,  0, 0,   0,   0,  0,  0,  0,   0,   NRM, NRM), 0, 0, 0));
        step(  V(0, 0,  9, 1,  3, 1,  0, 1,   1,   9,  0,  0,  0,   0,   STL, STL));

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
